demux_route_sequencer: RTL

Upstream control stage for the 1-to-11 demultiplexer in the CNN accelerator datapath. Accepts a valid/ready stream of words (e.g. kernel weights from the Avalon-side buffer) and drives the demux data, 4-bit selector and enable, so that each of the 11 destinations receives exactly WORDS_PER_DEST consecutive words, in order 0..10. A frame is one full sweep of all destinations, started by a pulse and closed by a done pulse.

---
 rtl/dseq_pkg.sv | 14 +
 rtl/dseq_mod_counter.sv | 22 ++
 rtl/demux_route_sequencer.sv | 107 ++++++++++
 3 files changed

// File: rtl/dseq_pkg.sv
// dseq_pkg: shared state encoding, sizing constants and skip-mask helper for the demux route sequencer
package dseq_pkg;
  localparam int DSEQ_SEL_WIDTH = 4;
  localparam int DSEQ_MAX_DEST = 11;
  localparam logic [DSEQ_SEL_WIDTH-1:0] DSEQ_NO_DEST = 4'hF;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} dseq_state_e;
  // lowest unmasked destination index at or above from; DSEQ_NO_DEST when none is left
  function automatic logic [DSEQ_SEL_WIDTH-1:0] next_unmasked(input logic [DSEQ_MAX_DEST-1:0] mask,
                                                              input logic [DSEQ_SEL_WIDTH-1:0] from);
    next_unmasked = DSEQ_NO_DEST;
    for (int i = DSEQ_MAX_DEST - 1; i >= 0; i--)
      if (i >= int'(from) && !mask[i]) next_unmasked = DSEQ_SEL_WIDTH'(i);
  endfunction
endpackage

// File: rtl/dseq_mod_counter.sv
// dseq_mod_counter: modulo-MODULUS counter with enable, synchronous clear and terminal-count flag
module dseq_mod_counter #(
  parameter int WIDTH = 8,
  parameter int MODULUS = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  assign cnt = cnt_q;
  assign tc = cnt_q == WIDTH'(MODULUS - 1);
  // clear wins over counting; wrap to zero after the terminal count
  always_comb cnt_d = clr ? '0 : en ? (tc ? '0 : cnt_q + WIDTH'(1)) : cnt_q;
  // count register, cleared asynchronously
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/demux_route_sequencer.sv
// demux_route_sequencer: steers a valid/ready word stream across the 1-to-NUM_DEST demux, WORDS_PER_DEST words per destination per frame.
// Optional build macro DSEQ_SKIP_MASK_EN adds DSEQ_Skip_mask, a per-frame set of destinations to skip.
module demux_route_sequencer
  import dseq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_DEST = 11,
  parameter int WORDS_PER_DEST = 9
) (
  input  logic                      DSEQ_CLOCK_50,
  input  logic                      DSEQ_RESET_InHigh,
  input  logic                      DSEQ_Start,
  input  logic [DATA_WIDTH-1:0]     DSEQ_Data_in,
  input  logic                      DSEQ_Valid_in,
`ifdef DSEQ_SKIP_MASK_EN
  input  logic [NUM_DEST-1:0]       DSEQ_Skip_mask,
`endif
  output logic                      DSEQ_Ready_out,
  output logic [DATA_WIDTH-1:0]     DSEQ_Data_out,
  output logic [DSEQ_SEL_WIDTH-1:0] DSEQ_Selector,
  output logic                      DSEQ_En,
  output logic                      DSEQ_Busy,
  output logic                      DSEQ_Done
);
  dseq_state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DSEQ_SEL_WIDTH-1:0] sel_q, sel_d, dest_cnt;
  logic en_q, en_d;
  logic [7:0] word_cnt;
  logic word_tc, accept, start_ok, last, start_empty, unused_word_cnt;

  assign accept = state_q == LOAD && DSEQ_Valid_in;
  assign start_ok = state_q == IDLE && DSEQ_Start;
  assign unused_word_cnt = ^word_cnt;

  dseq_mod_counter #(.WIDTH(8), .MODULUS(WORDS_PER_DEST)) u_word_cnt (
    .clk(DSEQ_CLOCK_50), .rst(DSEQ_RESET_InHigh), .en(accept), .clr(start_ok),
    .cnt(word_cnt), .tc(word_tc)
  );

`ifdef DSEQ_SKIP_MASK_EN
  logic [DSEQ_MAX_DEST-1:0] mask_q, mask_d, mask_in;
  logic [DSEQ_SEL_WIDTH-1:0] dest_q, dest_d, first_dest, next_dest;
  // indices at or above NUM_DEST read as skipped so the search never lands there
  always_comb begin
    mask_in = '1;
    mask_in[NUM_DEST-1:0] = DSEQ_Skip_mask;
  end
  assign first_dest = next_unmasked(mask_in, DSEQ_SEL_WIDTH'(0));
  assign next_dest = next_unmasked(mask_q, dest_q + 4'd1);
  assign start_empty = first_dest == DSEQ_NO_DEST;
  assign last = accept && word_tc && next_dest == DSEQ_NO_DEST;
  assign dest_cnt = dest_q;
  // capture the mask at frame start and hop dest_cnt over skipped destinations
  always_comb begin
    mask_d = start_ok ? mask_in : mask_q;
    dest_d = start_ok ? first_dest : (accept && word_tc) ? next_dest : dest_q;
  end
  // mask and destination registers
  always_ff @(posedge DSEQ_CLOCK_50 or posedge DSEQ_RESET_InHigh)
    if (DSEQ_RESET_InHigh) begin
      mask_q <= '0;
      dest_q <= '0;
    end else begin
      mask_q <= mask_d;
      dest_q <= dest_d;
    end
`else
  logic dest_tc;
  assign start_empty = 1'b0;
  assign last = accept && word_tc && dest_tc;
  dseq_mod_counter #(.WIDTH(DSEQ_SEL_WIDTH), .MODULUS(NUM_DEST)) u_dest_cnt (
    .clk(DSEQ_CLOCK_50), .rst(DSEQ_RESET_InHigh), .en(accept && word_tc), .clr(start_ok),
    .cnt(dest_cnt), .tc(dest_tc)
  );
`endif

  // next state and the one-cycle-latency demux write path
  always_comb begin
    state_d = state_q == IDLE ? (start_ok ? (start_empty ? DONE : LOAD) : IDLE)
            : state_q == LOAD ? (last ? DONE : LOAD) : IDLE;
    data_d = accept ? DSEQ_Data_in : data_q;
    sel_d = accept ? dest_cnt : sel_q;
    en_d = accept;
  end

  // state and output registers
  always_ff @(posedge DSEQ_CLOCK_50 or posedge DSEQ_RESET_InHigh)
    if (DSEQ_RESET_InHigh) begin
      state_q <= IDLE;
      data_q <= '0;
      sel_q <= '0;
      en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      sel_q <= sel_d;
      en_q <= en_d;
    end

  assign DSEQ_Ready_out = state_q == LOAD;
  assign DSEQ_Busy = state_q == LOAD;
  assign DSEQ_Done = state_q == DONE;
  assign DSEQ_Data_out = data_q;
  assign DSEQ_Selector = sel_q;
  assign DSEQ_En = en_q;
endmodule
